vu_meter_multich: RTL and testbench
===================================

// Module: vu_meter_multich
// PURPOSE
//  N-channel VU meter driver: rectifies signed audio samples per channel, averages or
//  peak-detects them over a fixed window, applies instant-attack/exponential-decay
//  ballistics and drives one PWM output per analogue meter. Sits beside the I2S/DSP
//  datapath on the 49.152 MHz audio clock. Supersedes the fixed 2-channel, 8-bit driver.
// PARAMETERS
//  NUM_CH        2    number of meter channels
//  SAMPLE_W      16   audio sample width, signed two's complement
//  AVG_LOG2      4    window = 2**AVG_LOG2 samples per channel
//  PWM_BITS      7    duty resolution; PWM frame = 2**PWM_BITS ticks
//  PWM_PRESCALE  64   clk cycles per PWM tick (>=2)
//  DECAY_SHIFT   3    decay step = (level-new)>>DECAY_SHIFT, minimum 1
// PORTS
//  clk           in   1                  audio system clock
//  rst_n         in   1                  asynchronous reset, active low
//  data_en       in   NUM_CH             per-channel 1-cycle sample strobe (~96 kHz)
//  audio_enable  in   1                  1 = music playing; 0 = clear and blank meters
//  audio_in      in   NUM_CH*SAMPLE_W    channel c at [c*SAMPLE_W +: SAMPLE_W]
//  mode          in   2                  0 average, 1 peak, 2 test, 3 reserved (=average)
//  test_duty     in   PWM_BITS           duty for all channels in test mode
//  window_stb    out  NUM_CH             1-cycle pulse per channel at window close
//  level_out     out  NUM_CH*PWM_BITS    current ballistic level per channel
//  vu_pwm_out    out  NUM_CH             PWM meter drive
// BEHAVIOUR
//  - Reset (async assert, sync release): all counters, accumulators, levels, duties,
//    window_stb, level_out, vu_pwm_out = 0.
//  - Rectify: mag = |x|, width SAMPLE_W-1; most-negative input saturates to all-ones.
//  - Per channel, on data_en[c] & audio_enable: sum += mag (width SAMPLE_W-1+AVG_LOG2,
//    no overflow possible), peak = max(peak, mag), sample count +1.
//  - Window close: the data_en that brings count to 2**AVG_LOG2 (sample included).
//    Next cycle: window_stb[c]=1, new = top PWM_BITS of (sum>>AVG_LOG2) in mode 0/3
//    or of peak in mode 1; sum, peak, count cleared in the same cycle as closing.
//  - Ballistics, same cycle as window_stb: new >= level -> level = new;
//    else level -= max(1, (level-new)>>DECAY_SHIFT). Never underflows below new.
//  - mode sampled at window close; mode change mid-window affects only the next close.
//    Sum and peak always both tracked.
//  - PWM: one prescaler (0..PWM_PRESCALE-1) and one phase counter (0..2**PWM_BITS-1)
//    shared by all channels; phase advances when prescaler wraps.
//    duty[c] latched only when phase==0 at tick (glitch-free); source = test_duty in
//    mode 2, else level[c]. vu_pwm_out[c] = (phase < duty[c]), registered.
//    duty 0 -> constantly low; duty 2**PWM_BITS-1 -> high 127/128 of frame (PWM_BITS=7).
//  - Mode 2 (test): PWM runs regardless of audio_enable and data_en; levels still update.
//  - audio_enable=0 (modes 0,1,3): sum/peak/count and level cleared synchronously,
//    window_stb held 0, vu_pwm_out forced 0 next cycle; partial window discarded.
//    Re-enable starts a fresh window; PWM counters never stop.
//  - data_en on several channels in one cycle: independent, no arbitration.
//  - Latency: last sample -> level_out = 1 clk; level -> PWM <= 1 frame.
// TESTING
//  1 Reset mid-PWM-high: assert rst_n=0 -> vu_pwm_out, level_out, window_stb = 0 same
//    cycle (async); release -> first window_stb after exactly 16 data_en.
//  2 Mode 0, ch0 constant +0x4000 x16 -> window_stb[0] 1 clk after 16th, level 0x40,
//    vu_pwm_out[0] high 64 of 128 ticks; ch1 idle stays 0.
//  3 Decay: level 0x40, then zeros -> levels 0x38,0x31,0x2B,... ends at 0 via min-step 1.
//  4 Mode 1, one 0x8000 sample among 15 zeros -> level 0x7F (saturation); mode 0
//    same data -> level 0x07.
//  5 Mode 2, test_duty=0x20 changed mid-frame to 0x10 -> old duty completes frame,
//    new 16/128 from next phase 0; all channels identical.
//  6 audio_enable dropped after 8 samples, re-raised -> outputs 0, next stb after 16 more.

Source files
------------

// File: rtl/vu_meter_multich.sv
// Multi-channel VU meter driver: per-channel rectify, windowed average/peak, attack/decay
// ballistics and a shared-counter PWM drive for each analogue meter.
module vu_meter_multich #(
  parameter int NUM_CH       = 2,
  parameter int SAMPLE_W     = 16,
  parameter int AVG_LOG2     = 4,
  parameter int PWM_BITS     = 7,
  parameter int PWM_PRESCALE = 64,
  parameter int DECAY_SHIFT  = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            data_en,
  input  logic                         audio_enable,
  input  logic [NUM_CH*SAMPLE_W-1:0]   audio_in,
  input  logic [1:0]                   mode,
  input  logic [PWM_BITS-1:0]          test_duty,
  output logic [NUM_CH-1:0]            window_stb,
  output logic [NUM_CH*PWM_BITS-1:0]   level_out,
  output logic [NUM_CH-1:0]            vu_pwm_out
);

  localparam int MAG_W = SAMPLE_W - 1;
  localparam int SUM_W = MAG_W + AVG_LOG2;
  localparam int PS_W  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(PWM_PRESCALE - 1);
  localparam logic [1:0]      MODE_PEAK = 2'd1;
  localparam logic [1:0]      MODE_TEST = 2'd2;

  logic [PS_W-1:0]     presc_q;
  logic [PWM_BITS-1:0] phase_q;
  logic                tick;
  logic                frame_end;
  logic                test_mode;
  logic                blank;

  assign tick      = (presc_q == PS_LAST);
  assign frame_end = tick && (phase_q == {PWM_BITS{1'b1}});
  assign test_mode = (mode == MODE_TEST);
  assign blank     = ~audio_enable & ~test_mode;

  // Shared PWM timebase; it never stops, so all meters stay frame-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      phase_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
      phase_q <= phase_q + PWM_BITS'(1);
    end else begin
      presc_q <= presc_q + PS_W'(1);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SAMPLE_W-1:0] smp;
    logic [SAMPLE_W-1:0] neg;
    logic [MAG_W-1:0]    mag;
    logic [MAG_W-1:0]    peak_q;
    logic [MAG_W-1:0]    peak_nxt;
    logic [SUM_W-1:0]    sum_q;
    logic [SUM_W-1:0]    sum_nxt;
    logic [AVG_LOG2-1:0] cnt_q;
    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] new_lvl;
    logic [PWM_BITS-1:0] diff;
    logic [PWM_BITS-1:0] shifted;
    logic [PWM_BITS-1:0] step;
    logic [PWM_BITS-1:0] level_nxt;
    logic                take;
    logic                close;
    logic                stb_q;
    logic                pwm_q;

    assign smp = audio_in[c*SAMPLE_W +: SAMPLE_W];
    assign neg = SAMPLE_W'(0) - smp;

    // Only the most-negative code still negates to a negative value; clamp it.
    always_comb begin
      if (!smp[SAMPLE_W-1])
        mag = smp[MAG_W-1:0];
      else if (neg[SAMPLE_W-1])
        mag = '1;
      else
        mag = neg[MAG_W-1:0];
    end

    assign take     = data_en[c] & audio_enable;
    assign close    = take & (cnt_q == {AVG_LOG2{1'b1}});
    assign sum_nxt  = sum_q + SUM_W'(mag);
    assign peak_nxt = (mag > peak_q) ? mag : peak_q;

    // Top bits of the sum are the top bits of the window average.
    assign new_lvl = (mode == MODE_PEAK) ? peak_nxt[MAG_W-1 -: PWM_BITS]
                                         : sum_nxt[SUM_W-1 -: PWM_BITS];

    assign diff      = level_q - new_lvl;
    assign shifted   = diff >> DECAY_SHIFT;
    assign step      = (shifted == '0) ? PWM_BITS'(1) : shifted;
    assign level_nxt = (new_lvl >= level_q) ? new_lvl : (level_q - step);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        peak_q  <= '0;
        cnt_q   <= '0;
        level_q <= '0;
        stb_q   <= 1'b0;
      end else if (blank) begin
        sum_q   <= '0;
        peak_q  <= '0;
        cnt_q   <= '0;
        level_q <= '0;
        stb_q   <= 1'b0;
      end else begin
        stb_q <= close;
        if (close) begin
          sum_q   <= '0;
          peak_q  <= '0;
          cnt_q   <= '0;
          level_q <= level_nxt;
        end else if (take) begin
          sum_q  <= sum_nxt;
          peak_q <= peak_nxt;
          cnt_q  <= cnt_q + AVG_LOG2'(1);
        end
      end
    end

    // Duty only changes at the frame boundary so a frame is never cut short.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_q <= '0;
        pwm_q  <= 1'b0;
      end else begin
        if (frame_end)
          duty_q <= test_mode ? test_duty : level_q;
        pwm_q <= ~blank & (phase_q < duty_q);
      end
    end

    assign window_stb[c]                      = stb_q;
    assign level_out[c*PWM_BITS +: PWM_BITS]  = level_q;
    assign vu_pwm_out[c]                      = pwm_q;
  end

endmodule

// File: tb/tb_vu_meter_multich.sv
// Bench for vu_meter_multich: directed scenarios plus random traffic, all checked every
// cycle against an arithmetic model of window averaging, ballistics and PWM framing.
module tb_vu_meter_multich;
  localparam int FRAME = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  data_en = '0;
  logic        audio_enable = 1'b0;
  logic [31:0] audio_in = '0;
  logic [1:0]  mode = '0;
  logic [6:0]  test_duty = '0;
  logic [1:0]  window_stb;
  logic [13:0] level_out;
  logic [1:0]  vu_pwm_out;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_on = 0;

  always #5 clk = ~clk;

  vu_meter_multich dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_en      (data_en),
    .audio_enable (audio_enable),
    .audio_in     (audio_in),
    .mode         (mode),
    .test_duty    (test_duty),
    .window_stb   (window_stb),
    .level_out    (level_out),
    .vu_pwm_out   (vu_pwm_out)
  );

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  int m_t;
  int m_sum[2], m_max[2], m_n[2], m_lvl[2], m_duty[2];
  int m_stb[2], m_pwm[2];
  int md_ph, md_mg, md_nw, md_st;
  bit md_blank;

  function automatic int mag_of(logic [15:0] x);
    int v;
    v = int'(x);
    if (x[15]) v = v - 65536;
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0;
      for (int c = 0; c < 2; c++) begin
        m_sum[c] = 0; m_max[c] = 0; m_n[c] = 0; m_lvl[c] = 0;
        m_duty[c] = 0; m_stb[c] = 0; m_pwm[c] = 0;
      end
    end else begin
      md_blank = !audio_enable && (mode != 2'd2);
      md_ph = (m_t / 64) % 128;
      for (int c = 0; c < 2; c++)
        m_pwm[c] = (!md_blank && (md_ph < m_duty[c])) ? 1 : 0;
      if ((m_t % FRAME) == FRAME - 1)
        for (int c = 0; c < 2; c++)
          m_duty[c] = (mode == 2'd2) ? int'(test_duty) : m_lvl[c];
      for (int c = 0; c < 2; c++) begin
        if (md_blank) begin
          m_sum[c] = 0; m_max[c] = 0; m_n[c] = 0; m_lvl[c] = 0; m_stb[c] = 0;
        end else begin
          m_stb[c] = 0;
          if (data_en[c] && audio_enable) begin
            md_mg = mag_of(audio_in[c*16 +: 16]);
            m_sum[c] += md_mg;
            if (md_mg > m_max[c]) m_max[c] = md_mg;
            m_n[c]++;
            if (m_n[c] == 16) begin
              md_nw = (mode == 2'd1) ? m_max[c] / 256 : (m_sum[c] / 16) / 256;
              if (md_nw >= m_lvl[c]) m_lvl[c] = md_nw;
              else begin
                md_st = (m_lvl[c] - md_nw) / 8;
                if (md_st < 1) md_st = 1;
                m_lvl[c] -= md_st;
              end
              m_stb[c] = 1;
              m_sum[c] = 0; m_max[c] = 0; m_n[c] = 0;
            end
          end
        end
      end
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (cmp_on && rst_n) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("ch%0d stb", c), int'(window_stb[c]), m_stb[c]);
        chk($sformatf("ch%0d level", c), int'(level_out[c*7 +: 7]), m_lvl[c]);
        chk($sformatf("ch%0d pwm", c), int'(vu_pwm_out[c]), m_pwm[c]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [1:0] en, input logic [15:0] s0, input logic [15:0] s1,
                      output logic [1:0] stb, output int l0, output int l1);
    @(negedge clk);
    data_en  = en;
    audio_in = {s1, s0};
    @(negedge clk);
    stb = window_stb;
    l0  = int'(level_out[6:0]);
    l1  = int'(level_out[13:7]);
    data_en = '0;
  endtask

  task automatic feed(input logic [1:0] en, input logic [15:0] s0, input logic [15:0] s1,
                      input int n, output int early);
    logic [1:0] stb;
    int l0, l1;
    early = 0;
    for (int i = 0; i < n; i++) begin
      send(en, s0, s1, stb, l0, l1);
      if (stb != 2'b00) early++;
    end
  endtask

  task automatic run_window(input logic [1:0] en, input logic [15:0] s0, input logic [15:0] s1,
                            output int early, output logic [1:0] stb, output int l0, output int l1);
    feed(en, s0, s1, 15, early);
    send(en, s0, s1, stb, l0, l1);
  endtask

  task automatic wait_frame_end();
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while ((m_t % FRAME) != 0 && i < FRAME + 10);
  endtask

  task automatic count_frame(input int change_at, input logic [6:0] new_td,
                             output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i == change_at) test_duty = new_td;
      h0 += int'(vu_pwm_out[0]);
      h1 += int'(vu_pwm_out[1]);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] stb;
    int l0, l1, e, h0, h1, w, i;
    int dec_exp[3];
    dec_exp[0] = 'h38; dec_exp[1] = 'h31; dec_exp[2] = 'h2B;

    // reset state
    #23;
    chk("reset stb", int'(window_stb), 0);
    chk("reset level", int'(level_out), 0);
    chk("reset pwm", int'(vu_pwm_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_on = 1;
    audio_enable = 1'b1;
    mode = 2'd0;

    // mode 0 constant 0x4000 on ch0, ch1 idle
    run_window(2'b01, 16'h4000, 16'h0000, e, stb, l0, l1);
    chk("t2 early stb", e, 0);
    chk("t2 stb", int'(stb), 1);
    chk("t2 level ch0", l0, 'h40);
    chk("t2 level ch1", l1, 0);
    wait_frame_end();
    count_frame(-1, 7'd0, h0, h1);
    chk("t2 pwm ch0 high cycles", h0, 64 * 64);
    chk("t2 pwm ch1 high cycles", h1, 0);

    // async reset while the meter output is high
    i = 0;
    while (vu_pwm_out[0] !== 1'b1 && i < 20000) begin
      @(negedge clk);
      i++;
    end
    chk("t1 pwm high before reset", int'(vu_pwm_out[0]), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1 async stb", int'(window_stb), 0);
    chk("t1 async level", int'(level_out), 0);
    chk("t1 async pwm", int'(vu_pwm_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_window(2'b01, 16'h4000, 16'h0000, e, stb, l0, l1);
    chk("t1 no stb before 16th", e, 0);
    chk("t1 stb on 16th", int'(stb), 1);
    chk("t1 level ch0", l0, 'h40);

    // decay toward zero
    for (int k = 0; k < 3; k++) begin
      run_window(2'b01, 16'h0000, 16'h0000, e, stb, l0, l1);
      chk($sformatf("t3 decay step %0d", k), l0, dec_exp[k]);
    end
    w = 0;
    while (l0 != 0 && w < 80) begin
      run_window(2'b01, 16'h0000, 16'h0000, e, stb, l0, l1);
      w++;
    end
    chk("t3 decays to zero", l0, 0);

    // peak vs average on a single full-scale negative sample
    mode = 2'd1;
    send(2'b11, 16'h8000, 16'hC000, stb, l0, l1);
    feed(2'b11, 16'h0000, 16'hC000, 14, e);
    send(2'b11, 16'h0000, 16'hC000, stb, l0, l1);
    chk("t4 peak stb", int'(stb), 3);
    chk("t4 peak level ch0", l0, 'h7F);
    chk("t4 peak level ch1", l1, 'h40);
    @(negedge clk);
    audio_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t4 cleared level", int'(level_out), 0);
    chk("t4 blanked pwm", int'(vu_pwm_out), 0);
    audio_enable = 1'b1;
    mode = 2'd0;
    send(2'b11, 16'h8000, 16'hC000, stb, l0, l1);
    feed(2'b11, 16'h0000, 16'hC000, 14, e);
    send(2'b11, 16'h0000, 16'hC000, stb, l0, l1);
    chk("t4 avg level ch0", l0, 'h07);
    chk("t4 avg level ch1", l1, 'h40);

    // audio_enable drop mid-window
    feed(2'b11, 16'h7000, 16'h1234, 8, e);
    @(negedge clk);
    audio_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6 level while disabled", int'(level_out), 0);
    chk("t6 pwm while disabled", int'(vu_pwm_out), 0);
    chk("t6 stb while disabled", int'(window_stb), 0);
    audio_enable = 1'b1;
    run_window(2'b11, 16'h7000, 16'h1234, e, stb, l0, l1);
    chk("t6 no stb before 16 fresh", e, 0);
    chk("t6 stb after 16 fresh", int'(stb), 3);
    chk("t6 level ch0", l0, 'h70);
    chk("t6 level ch1", l1, 'h12);

    // test mode duty change mid-frame, independent of audio_enable
    mode = 2'd2;
    test_duty = 7'h20;
    audio_enable = 1'b0;
    wait_frame_end();
    count_frame(4000, 7'h10, h0, h1);
    chk("t5 old duty ch0", h0, 32 * 64);
    chk("t5 old duty ch1", h1, 32 * 64);
    count_frame(-1, 7'd0, h0, h1);
    chk("t5 new duty ch0", h0, 16 * 64);
    chk("t5 new duty ch1", h1, 16 * 64);

    // random traffic
    audio_enable = 1'b1;
    mode = 2'd0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      data_en = 2'($urandom_range(0, 3));
      audio_in[15:0]  = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      audio_in[31:16] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) test_duty = 7'($urandom);
      audio_enable = ($urandom_range(0, 249) != 0);
    end
    @(negedge clk);
    data_en = '0;
    repeat (4) @(negedge clk);
    cmp_on = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
